// File: rtl/core_run_controller_pkg.sv
// Shared command and state encodings for the run controller, its bench and the core wrapper.
package core_run_controller_pkg;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_LOAD  = 3'd1,
    CMD_RUN   = 3'd2,
    CMD_HALT  = 3'd3,
    CMD_STEP  = 3'd4,
    CMD_CLEAR = 3'd5,
    CMD_SETBP = 3'd6,
    CMD_CLRBP = 3'd7
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_RUN    = 3'd1,
    ST_HALTED = 3'd2,
    ST_STEP   = 3'd3
  } state_t;

endpackage

// File: rtl/core_run_controller_retire_counter.sv
// Retired-instruction counter: sync clear beats enable, wraps silently.
module retire_counter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  output logic [XLEN-1:0] count
);

  // Count one per enabled edge; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + XLEN'(1);
  end

endmodule

// File: rtl/core_run_controller.sv
// Host-facing sequencer for the single-cycle core: reset hold, program load,
// run / halt / single-step and a single PC breakpoint.
module core_run_controller
  import core_run_controller_pkg::*;
#(
  parameter int IMEM_AW = 6,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [IMEM_AW-1:0] cmd_addr,
  input  logic [XLEN-1:0]    cmd_data,
  input  logic [XLEN-1:0]    core_pc,
  output logic               core_reset,
  output logic               core_en,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic [2:0]         state_o,
  output logic [XLEN-1:0]    retired,
  output logic               err
);

  state_t         state, state_nx;
  cmd_op_t        op;
  logic           accept, hit, illegal, load_ok, clear;
  logic           skip, bp_en;
  logic [XLEN-1:0] bp_addr;

  assign op         = cmd_op_t'(cmd_op);
  assign cmd_ready  = (state != ST_STEP);
  assign accept     = cmd_valid & cmd_ready;
  // skip masks the breakpoint for the first cycle after resuming from it
  assign hit        = bp_en & (core_pc == bp_addr) & ~skip & (state == ST_RUN);
  assign core_en    = ((state == ST_RUN) & ~hit) | (state == ST_STEP);
  assign core_reset = (state == ST_HOLD);
  assign state_o    = state;
  assign clear      = accept & (op == CMD_CLEAR);

  // Next state plus command legality; autonomous moves first, accepted command overrides.
  always_comb begin
    state_nx = state;
    illegal  = 1'b0;
    load_ok  = 1'b0;
    case (state)
      ST_STEP: state_nx = ST_HALTED;
      ST_RUN:  if (hit) state_nx = ST_HALTED;
      default: ;
    endcase
    if (accept) begin
      case (op)
        CMD_LOAD:  if (state == ST_RUN) illegal = 1'b1;
                   else load_ok = 1'b1;
        CMD_RUN:   if (state == ST_HOLD || state == ST_HALTED) state_nx = ST_RUN;
        CMD_HALT:  if (state == ST_RUN) state_nx = ST_HALTED;
                   else illegal = 1'b1;
        CMD_STEP:  if (state == ST_RUN) illegal = 1'b1;
                   else state_nx = ST_STEP;
        CMD_CLEAR: state_nx = ST_HOLD;
        default:   ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_HOLD;
    else       state <= state_nx;
  end

  // LOAD register stage: one write strobe per accepted legal LOAD, the cycle after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= load_ok;
      if (load_ok) begin
        imem_addr  <= cmd_addr;
        imem_wdata <= cmd_data;
      end
    end
  end

  // Breakpoint register and resume-skip flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_en   <= 1'b0;
      bp_addr <= '0;
      skip    <= 1'b0;
    end else begin
      if (accept && op == CMD_SETBP) begin
        bp_en   <= 1'b1;
        bp_addr <= cmd_data;
      end else if (accept && op == CMD_CLRBP) begin
        bp_en <= 1'b0;
      end
      if (accept && op == CMD_RUN && state == ST_HALTED) skip <= 1'b1;
      else if (state == ST_RUN)                          skip <= 1'b0;
    end
  end

  // Sticky error: set by an illegal command, cleared only by CLEAR or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err <= 1'b0;
    else if (clear)   err <= 1'b0;
    else if (illegal) err <= 1'b1;
  end

  retire_counter #(.XLEN(XLEN)) u_retire (
    .clk   (clk),
    .rst   (reset),
    .en    (core_en),
    .clr   (clear),
    .count (retired)
  );

endmodule
